// File: rtl/trace_match_event_encoder.sv
// trace_match_event_encoder
//   Turns per-cycle match-rule hits from the trace pattern matcher into timestamped
//   sniff-FIFO words. A short gap (< 64 cycles) produces one DATA word. A long gap
//   produces a TIME word followed by a DATA word whose short time is relative to it.
//
// Ports
//   trace_clk        sole clock
//   reset            synchronous, active-high
//   capture_en       high while armed/capturing
//   match_valid      one-cycle strobe: at least one enabled rule matched
//   match_rule       bitmask of matching rules, qualified by match_valid
//   fifo_full        FIFO programmable-full (fewer than 2 entries free)
//   fifo_wr_en       registered FIFO write strobe
//   fifo_wr_data     registered FIFO write word
//   overflow_blocked sticky: a word was dropped because the FIFO was full
module trace_match_event_encoder #(
  parameter int unsigned pFULL_LEN  = 16,
  parameter int unsigned pNUM_RULES = 8
) (
  input  logic                  trace_clk,
  input  logic                  reset,
  input  logic                  capture_en,
  input  logic                  match_valid,
  input  logic [pNUM_RULES-1:0] match_rule,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [pFULL_LEN+1:0]  fifo_wr_data,
  output logic                  overflow_blocked
);

  localparam int unsigned ShortLen = 6;
  localparam int unsigned WordW    = pFULL_LEN + 2;

  localparam logic [1:0] CmdData = 2'b00;
  localparam logic [1:0] CmdTime = 2'b10;

  typedef enum logic {StIdle, StPend} state_e;

  state_e                 state_q, state_d;
  logic [pFULL_LEN-1:0]   cnt_q, cnt_d;
  logic [pNUM_RULES-1:0]  pend_rule_q, pend_rule_d;
  logic [ShortLen-1:0]    pend_time_q, pend_time_d;
  logic                   wr_en_q, wr_en_d;
  logic [WordW-1:0]       wr_data_q, wr_data_d;
  logic                   blocked_q, blocked_d;

  logic                   evt;
  logic                   is_short;
  logic                   want_wr;
  logic [WordW-1:0]       word;
  logic                   halt;

  function automatic logic [WordW-1:0] data_word(logic [ShortLen-1:0]   t,
                                                 logic [pNUM_RULES-1:0] r);
    logic [WordW-1:0] w;
    w = '0;
    w[1:0] = CmdData;
    w[ShortLen+1:2] = t;
    w[ShortLen+2 +: pNUM_RULES] = r;
    return w;
  endfunction

  function automatic logic [WordW-1:0] time_word(logic [pFULL_LEN-1:0] t);
    return {t, CmdTime};
  endfunction

  assign evt      = capture_en & match_valid;
  assign is_short = (cnt_q[pFULL_LEN-1:ShortLen] == '0);

  // Inter-event counter: held at 0 when disarmed, restarts at 1 after an event,
  // saturates rather than wrapping so a maxed TIME word means "at least this long".
  always_comb begin
    cnt_d = cnt_q;
    if (!capture_en) begin
      cnt_d = '0;
    end else if (evt) begin
      cnt_d = pFULL_LEN'(1);
    end else if (!(&cnt_q)) begin
      cnt_d = cnt_q + pFULL_LEN'(1);
    end
  end

  // Candidate word for this cycle, before arming/overflow gating.
  always_comb begin
    want_wr = 1'b0;
    word    = '0;
    unique case (state_q)
      StIdle: begin
        if (evt) begin
          want_wr = 1'b1;
          word    = is_short ? data_word(cnt_q[ShortLen-1:0], match_rule) : time_word(cnt_q);
        end
      end
      StPend: begin
        want_wr = 1'b1;
        word    = data_word(pend_time_q, pend_rule_q);
      end
    endcase
  end

  // Disarm, an existing block, or a fresh drop all abandon any pending word.
  assign halt = !capture_en || blocked_q || (want_wr && fifo_full);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (halt) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (evt && !is_short) state_d = StPend;
        StPend: state_d = evt ? StPend : StIdle;
      endcase
    end
  end

  // Output / datapath logic.
  always_comb begin
    wr_en_d     = !halt && want_wr;
    wr_data_d   = (!halt && want_wr) ? word : '0;
    blocked_d   = capture_en && (blocked_q || (want_wr && fifo_full));
    pend_rule_d = '0;
    pend_time_d = '0;
    if (state_d == StPend) begin
      // After a TIME word the DATA is relative to it (0); back-to-back events are 1 apart.
      pend_rule_d = match_rule;
      pend_time_d = (state_q == StPend) ? ShortLen'(1) : '0;
    end
  end

  always_ff @(posedge trace_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pend_rule_q <= '0;
      pend_time_q <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      blocked_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_rule_q <= pend_rule_d;
      pend_time_q <= pend_time_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      blocked_q   <= blocked_d;
    end
  end

  assign fifo_wr_en       = wr_en_q;
  assign fifo_wr_data     = wr_data_q;
  assign overflow_blocked = blocked_q;

endmodule
